// File: rtl/pwmtx_pkg.sv
// Shared RC-PWM timing constants and helpers for the pwmtx/pwmrx pair.
// Widths and frame lengths are in microsecond ticks.
package pwmtx_pkg;

    localparam int RC_MIN_US   = 1000;
    localparam int RC_MID_US   = 1500;
    localparam int RC_MAX_US   = 2000;
    localparam int RC_FRAME_US = 20000;

    function automatic logic [31:0] clamp_width(input logic [31:0] value,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Tick prescaler: counts 0..DIV-1 while enabled and strobes at the wrap.
// clear_in forces the count back to zero on the next edge.
module pwm_tick_gen #(
    parameter int DIV = 12
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic enable_in,
    input  logic clear_in,
    output logic tick_out
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count <= '0;
        end else if (clear_in) begin
            count <= '0;
        end else if (enable_in) begin
            if (count == LAST) count <= '0;
            else               count <= count + CW'(1);
        end
    end

    assign tick_out = enable_in && !clear_in && (count == LAST);

endmodule

// File: rtl/pwmtx.sv
// RC/servo PWM transmitter: double-buffered width commands applied at frame
// boundaries, with a failsafe width once commands stop arriving.
module pwmtx
    import pwmtx_pkg::*;
#(
    parameter int SIZE           = 16,
    parameter int SYSCLK         = 12000000,
    parameter int TICK_HZ        = 1000000,
    parameter int FRAME_TICKS    = RC_FRAME_US,
    parameter int MIN_WIDTH      = RC_MIN_US,
    parameter int MAX_WIDTH      = RC_MAX_US,
    parameter int FAILSAFE_WIDTH = RC_MID_US,
    parameter int TIMEOUT_FRAMES = 50
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            enable_in,
    input  logic [SIZE-1:0] width_in,
    input  logic            width_valid_in,
    output logic            r_width_ready_out,
    output logic            r_pulse_out,
    output logic            r_frame_out,
    output logic            r_failsafe_out
);

    localparam int DIV = SYSCLK / TICK_HZ;
    localparam int TW  = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
    localparam logic [SIZE-1:0] FRAME_LAST = SIZE'(FRAME_TICKS - 1);
    localparam logic [SIZE-1:0] FS_WIDTH   = SIZE'(FAILSAFE_WIDTH);
    localparam logic [TW-1:0]   TO_LIMIT   = TW'(TIMEOUT_FRAMES);

    logic            tick;
    logic            started;
    logic            frame_start;
    logic            accept;
    logic            load;
    logic            timed_out;
    logic [SIZE-1:0] frame_cnt;
    logic [SIZE-1:0] frame_cnt_next;
    logic [SIZE-1:0] active_w;
    logic [SIZE-1:0] active_w_next;
    logic [SIZE-1:0] pending_w;
    logic [SIZE-1:0] clamped;
    logic [TW-1:0]   to_cnt;
    logic [TW-1:0]   to_cnt_next;

    pwm_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .enable_in (enable_in),
        .clear_in  (!enable_in),
        .tick_out  (tick)
    );

    // Handshake: a width is taken on any clk where width_valid_in and
    // r_width_ready_out are both high; ready is low exactly while the pending
    // slot holds a value that has not yet been applied at a frame start.
    assign accept      = width_valid_in && r_width_ready_out;
    assign load        = frame_start && !r_width_ready_out;
    assign frame_start = tick && (!started || (frame_cnt == FRAME_LAST));
    assign clamped     = SIZE'(clamp_width(32'(width_in), 32'(MIN_WIDTH), 32'(MAX_WIDTH)));

    always_comb begin
        frame_cnt_next = frame_start ? '0 : frame_cnt + SIZE'(1);
        active_w_next  = active_w;
        to_cnt_next    = to_cnt;
        timed_out      = 1'b0;
        if (load) begin
            active_w_next = pending_w;
            to_cnt_next   = '0;
        end else if (frame_start) begin
            if (to_cnt != TO_LIMIT) to_cnt_next = to_cnt + TW'(1);
            if ((TIMEOUT_FRAMES != 0) && (to_cnt_next == TO_LIMIT)) begin
                timed_out     = 1'b1;
                active_w_next = FS_WIDTH;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            frame_cnt         <= '0;
            started           <= 1'b0;
            active_w          <= FS_WIDTH;
            pending_w         <= '0;
            to_cnt            <= '0;
            r_width_ready_out <= 1'b1;
            r_pulse_out       <= 1'b0;
            r_frame_out       <= 1'b0;
            r_failsafe_out    <= 1'b1;
        end else begin
            r_frame_out <= frame_start;
            active_w    <= active_w_next;
            to_cnt      <= to_cnt_next;

            if (load)           r_failsafe_out <= 1'b0;
            else if (timed_out) r_failsafe_out <= 1'b1;

            // accept and load are exclusive: one needs ready high, the other low
            if (accept) begin
                pending_w         <= clamped;
                r_width_ready_out <= 1'b0;
            end else if (load) begin
                r_width_ready_out <= 1'b1;
            end

            if (!enable_in) begin
                frame_cnt   <= '0;
                started     <= 1'b0;
                r_pulse_out <= 1'b0;
            end else if (tick) begin
                frame_cnt   <= frame_cnt_next;
                started     <= 1'b1;
                r_pulse_out <= (frame_cnt_next < active_w_next);
            end
        end
    end

endmodule
